// File: rtl/elevator_link_pkg.sv
// elevator_link_pkg: shared frame constants, types and helpers for the elevator serial link (receive decoder and status serializer)
package elevator_link_pkg;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int FRAME_LEN = 8;
    localparam int PAYLOAD_LEN = FRAME_LEN - 2;
    localparam int P_HALL_LO = 0;
    localparam int P_HALL_HI = 1;
    localparam int P_CAR1 = 2;
    localparam int P_CAR2 = 3;
    localparam int P_CAR3 = 4;
    localparam int P_CAR_HI = 5;
    localparam logic [7:0] RSV_HALL_HI = 8'hF0;
    localparam logic [7:0] RSV_CAR_HI = 8'hF8;

    typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CSUM} rx_state_t;

    typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

    typedef struct packed {
        logic [8:0]  car3;
        logic [8:0]  car2;
        logic [8:0]  car1;
        logic [11:0] hall;
    } buttons_t;

    function automatic buttons_t assemble_buttons(input payload_t p);
        buttons_t b;
        b.hall = {p[P_HALL_HI][3:0], p[P_HALL_LO]};
        b.car1 = {p[P_CAR_HI][0], p[P_CAR1]};
        b.car2 = {p[P_CAR_HI][1], p[P_CAR2]};
        b.car3 = {p[P_CAR_HI][2], p[P_CAR3]};
        return b;
    endfunction

    function automatic logic reserved_clear(input payload_t p);
        return ((p[P_HALL_HI] & RSV_HALL_HI) | (p[P_CAR_HI] & RSV_CAR_HI)) == 8'h00;
    endfunction
endpackage

// File: rtl/link_timeout_counter.sv
// link_timeout_counter: saturating idle counter; clk/reset, restart clears, enable counts, expired flags the last idle cycle
module link_timeout_counter #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    localparam logic [W-1:0] FULL = W'(CYCLES);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) r_cnt <= '0;
        else if (enable && r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
    end

    // a restarting byte in the same cycle rescues the frame
    assign expired = enable && !restart && r_cnt == LAST;
endmodule

// File: rtl/elevator_button_frame_decoder.sv
// elevator_button_frame_decoder: validates 8-byte button frames from the UART and pulses newly pressed buttons
//   in : clk, reset (sync, active-high), rxData/rxValid (received byte), rxFrameErr (stop-bit error)
//   out: newRealFloorButton[11:0], newInternalButton1..3[9:1] (rising-edge pulses), frameOk, frameErr
module elevator_button_frame_decoder
    import elevator_link_pkg::*;
#(
    parameter int         CLKFRQ        = 100000000,
    parameter int         BAUDRATE      = 9600,
    parameter int         TIMEOUT_BYTES = 3,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    input  logic        rxFrameErr,
    output logic [11:0] newRealFloorButton,
    output logic [9:1]  newInternalButton1,
    output logic [9:1]  newInternalButton2,
    output logic [9:1]  newInternalButton3,
    output logic        frameOk,
    output logic        frameErr
);
    // 64-bit math: the default product overflows a 32-bit int
    localparam longint TO_L = longint'(TIMEOUT_BYTES) * 10 * longint'(CLKFRQ) / longint'(BAUDRATE);
    localparam int TO_CYC = int'(TO_L);

    rx_state_t r_state, w_next;
    logic [2:0] r_idx;
    logic [7:0] r_acc;
    payload_t   r_pay;
    buttons_t   r_held, r_out, w_asm, w_new;
    logic       w_byte, w_expired, w_abort, w_good, w_pass, w_fail;

    // a byte coinciding with a stop-bit error is discarded
    assign w_byte  = rxValid && !rxFrameErr;
    assign w_abort = r_state != ST_HUNT && (rxFrameErr || w_expired);
    assign w_good  = rxData == r_acc && reserved_clear(r_pay);
    assign w_asm   = assemble_buttons(r_pay);
    assign w_new   = w_asm & ~r_held;

    link_timeout_counter #(.CYCLES(TO_CYC)) u_timeout (
        .clk(clk),
        .reset(reset),
        .restart(w_byte),
        .enable(r_state != ST_HUNT),
        .expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        w_pass = 1'b0;
        w_fail = 1'b0;
        if (w_abort) begin
            w_next = ST_HUNT;
            w_fail = 1'b1;
        end else if (w_byte) begin
            case (r_state)
                ST_HUNT:    w_next = rxData == HEADER ? ST_PAYLOAD : ST_HUNT;
                ST_PAYLOAD: w_next = r_idx == 3'(PAYLOAD_LEN - 1) ? ST_CSUM : ST_PAYLOAD;
                default: begin
                    w_next = ST_HUNT;
                    w_pass = w_good;
                    w_fail = !w_good;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_HUNT;
            r_idx    <= '0;
            r_acc    <= '0;
            r_pay    <= '0;
            r_held   <= '0;
            r_out    <= '0;
            frameOk  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            r_state  <= w_next;
            frameOk  <= w_pass;
            frameErr <= w_fail;
            r_out    <= w_pass ? w_new : '0;
            if (w_pass) r_held <= w_asm;
            // HUNT keeps index and checksum cleared so a header starts a fresh frame
            if (r_state == ST_HUNT) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (r_state == ST_PAYLOAD && w_byte) begin
                r_pay[r_idx] <= rxData;
                r_acc        <= r_acc ^ rxData;
                r_idx        <= r_idx + 3'd1;
            end
        end
    end

    assign newRealFloorButton = r_out.hall;
    assign newInternalButton1 = r_out.car1;
    assign newInternalButton2 = r_out.car2;
    assign newInternalButton3 = r_out.car3;
endmodule

// File: tb/tb_elevator_button_frame_decoder.sv
// tb_elevator_button_frame_decoder: scoreboard bench for the elevator button frame decoder
module tb_elevator_button_frame_decoder;
    localparam int CLKF = 96000;
    localparam int BAUD = 9600;
    localparam int TOB  = 3;
    localparam int T    = TOB * 10 * CLKF / BAUD;
    localparam logic [7:0] HDR = 8'hA5;

    typedef struct {
        logic [11:0] hall;
        logic [8:0]  c1;
        logic [8:0]  c2;
        logic [8:0]  c3;
        logic        ok;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxValid = 1'b0;
    logic        rxFrameErr = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic [11:0] hall_o;
    logic [9:1]  c1_o, c2_o, c3_o;
    logic        ok_o, err_o;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [38:0] held_m = '0;

    elevator_button_frame_decoder #(
        .CLKFRQ(CLKF),
        .BAUDRATE(BAUD),
        .TIMEOUT_BYTES(TOB),
        .HEADER(HDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxData(rxData),
        .rxValid(rxValid),
        .rxFrameErr(rxFrameErr),
        .newRealFloorButton(hall_o),
        .newInternalButton1(c1_o),
        .newInternalButton2(c2_o),
        .newInternalButton3(c3_o),
        .frameOk(ok_o),
        .frameErr(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_output: nothing seen, required at cycle %0d (now %0d)", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (ok_o || err_o || hall_o != 0 || c1_o != 0 || c2_o != 0 || c3_o != 0) begin
            checks++;
            if (q.size() == 0 || q[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_output at cycle %0d: hall=%h c1=%h c2=%h c3=%h ok=%b err=%b, required none",
                         cyc, hall_o, c1_o, c2_o, c3_o, ok_o, err_o);
            end else begin
                e = q.pop_front();
                if ({hall_o, c1_o, c2_o, c3_o, ok_o, err_o} !== {e.hall, e.c1, e.c2, e.c3, e.ok, e.err}) begin
                    errors++;
                    $display("FAIL frame_result at cycle %0d: got hall=%h c1=%h c2=%h c3=%h ok=%b err=%b, required hall=%h c1=%h c2=%h c3=%h ok=%b err=%b",
                             cyc, hall_o, c1_o, c2_o, c3_o, ok_o, err_o, e.hall, e.c1, e.c2, e.c3, e.ok, e.err);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr = 1'b0);
        rxData = b;
        rxValid = 1'b1;
        rxFrameErr = ferr;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        rxFrameErr = 1'b0;
    endtask

    task automatic push_err(input int due);
        exp_t e;
        e = '{hall: '0, c1: '0, c2: '0, c3: '0, ok: 1'b0, err: 1'b1, due: due};
        q.push_back(e);
    endtask

    task automatic build(input logic [11:0] h, input logic [8:0] a, b, c, input logic [3:0] rsv,
                         output logic [7:0] by [8]);
        by[0] = HDR;
        by[1] = h[7:0];
        by[2] = {rsv, h[11:8]};
        by[3] = a[7:0];
        by[4] = b[7:0];
        by[5] = c[7:0];
        by[6] = {5'b0, c[8], b[8], a[8]};
        by[7] = by[1] ^ by[2] ^ by[3] ^ by[4] ^ by[5] ^ by[6];
    endtask

    task automatic send_frame(input logic [11:0] h, input logic [8:0] a, b, c,
                              input logic [7:0] cx = 8'h00, input logic [3:0] rsv = 4'h0, input int gap = 0);
        logic [7:0]  by [8];
        logic [38:0] asm, nw;
        exp_t        e;
        build(h, a, b, c, rsv, by);
        for (int i = 0; i < 8; i++) begin
            send_byte(i == 7 ? by[i] ^ cx : by[i]);
            if (gap > 0 && i < 7) idle(gap);
        end
        asm = {c, b, a, h};
        e.ok = cx == 8'h00 && rsv == 4'h0;
        e.err = !e.ok;
        nw = '0;
        if (e.ok) begin
            nw = asm & ~held_m;
            held_m = asm;
        end
        e.hall = nw[11:0];
        e.c1 = nw[20:12];
        e.c2 = nw[29:21];
        e.c3 = nw[38:30];
        e.due = cyc;
        q.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        held_m = '0;
        checks++;
        if (hall_o !== 12'h000) begin errors++; $display("FAIL reset_hall: got %h required 000", hall_o); end
        checks++;
        if ({c1_o, c2_o, c3_o} !== 27'h0) begin errors++; $display("FAIL reset_car: got %h %h %h required 0", c1_o, c2_o, c3_o); end
        checks++;
        if ({ok_o, err_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got ok=%b err=%b required 0 0", ok_o, err_o); end
        reset = 1'b0;
        idle(2);
        checks++;
        if ({hall_o, c1_o, c2_o, c3_o, ok_o, err_o} !== '0) begin errors++; $display("FAIL post_reset_idle: outputs not 0"); end
    endtask

    task automatic test_basic;
        send_frame(12'h005, 9'h003, 9'h000, 9'h000);
        idle(2);
        send_frame(12'h005, 9'h003, 9'h000, 9'h000);
        idle(2);
        send_frame(12'h007, 9'h003, 9'h000, 9'h000);
        idle(2);
        send_frame(12'hA5C, 9'h1F0, 9'h155, 9'h1AA);
        idle(2);
        send_frame(12'h0A5, 9'h100, 9'h0FF, 9'h101);
        idle(2);
    endtask

    task automatic test_bad_checksum;
        send_frame(12'hFFF, 9'h1FF, 9'h1FF, 9'h1FF, 8'h01);
        idle(2);
        send_frame(12'h00F, 9'h001, 9'h000, 9'h002, 8'h00, 4'h1);
        idle(2);
        send_frame(12'h80F, 9'h001, 9'h002, 9'h003);
        idle(2);
    endtask

    task automatic test_timeout;
        send_byte(HDR);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        push_err(cyc + T);
        idle(T + 4);
        send_frame(12'h000, 9'h000, 9'h000, 9'h000);
        idle(2);
        send_frame(12'h010, 9'h010, 9'h010, 9'h010, 8'h00, 4'h0, T - 1);
        idle(2);
    endtask

    task automatic test_garbage;
        send_byte(8'h00);
        send_byte(8'hFF);
        rxFrameErr = 1'b1;
        idle(1);
        rxFrameErr = 1'b0;
        send_byte(HDR, 1'b1);
        send_byte(8'h00);
        idle(2);
        send_frame(12'h123, 9'h045, 9'h067, 9'h089);
        idle(2);
    endtask

    task automatic test_aborts;
        logic [7:0] by [8];
        build(12'hFFF, 9'h1FF, 9'h1FF, 9'h1FF, 4'h0, by);
        for (int i = 0; i < 4; i++) send_byte(by[i]);
        send_byte(by[4], 1'b1);
        push_err(cyc);
        idle(3);
        send_frame(12'h300, 9'h000, 9'h000, 9'h000);
        idle(2);
        for (int i = 0; i < 5; i++) send_byte(by[i]);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        held_m = '0;
        idle(2);
        send_frame(12'h300, 9'h004, 9'h000, 9'h000);
        idle(2);
    endtask

    task automatic test_back_to_back;
        send_frame(12'h001, 9'h000, 9'h000, 9'h000);
        send_frame(12'h003, 9'h000, 9'h000, 9'h000);
        send_frame(12'h002, 9'h001, 9'h000, 9'h000);
        idle(3);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bad_checksum;
        test_timeout;
        test_garbage;
        test_aborts;
        test_back_to_back;
        for (int i = 0; i < 200 && q.size() > 0; i++) idle(1);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected results never produced, required 0", q.size());
        end
        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
